// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the fetch-side PC sequencer.
//               Optional feature macro: PC_SEQ_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_e;

    localparam logic [31:0] PKG_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PKG_TRAP_VECTOR  = 32'h0000_0004;
    localparam logic [31:0] PKG_PC_STEP      = 32'd4;

    // A redirect target is misaligned when it is not on a word boundary
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_buf
// Description : Holds one pending branch redirect (valid bit + target) until
//               the next PC update consumes it. Last load wins.
//               Optional feature macro: PC_SEQ_ALIGN_CHECK_EN (not used here).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] target_i,
    input  logic        clear_i,
    output logic        valid_o,
    output logic [31:0] target_o
);

    logic        valid_q;
    logic [31:0] target_q;

    // Capture a redirect; consumption by an update takes priority over a load
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            target_q <= 32'h0000_0000;
        end else if (clear_i) begin
            valid_q  <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            target_q <= target_i;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-side controller that sequences the external pcreg
//               register: boot vector, sequential step, branch redirects,
//               stall hold and halt/run control, plus a retired counter.
//               Optional feature macro: PC_SEQ_ALIGN_CHECK_EN (misaligned
//               redirect targets are replaced by TRAP_VECTOR).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PKG_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = PKG_TRAP_VECTOR,
    parameter logic [31:0] PC_STEP      = PKG_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    output logic        pc_ena,
    output logic [31:0] pc_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        halt,
    input  logic        run,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] retired,
    output logic        misalign_err
);

    pc_state_e   state_q;
    pc_state_e   state_d;
    logic [31:0] retired_q;

    logic        w_boot;
    logic        w_update;
    logic        w_pend_valid;
    logic [31:0] w_pend_target;
    logic        w_redirect;
    logic [31:0] w_redir_target;
    logic        w_misalign;
    logic [31:0] w_next_pc;

    pc_redirect_buf u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (br_valid & ~w_update),
        .target_i (br_target),
        .clear_i  (w_update),
        .valid_o  (w_pend_valid),
        .target_o (w_pend_target)
    );

    // Next-PC selection: live redirect, then pending redirect, then step
    always_comb begin
        w_redirect     = br_valid | w_pend_valid;
        w_redir_target = br_valid ? br_target : w_pend_target;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        w_misalign     = w_redirect & is_misaligned(w_redir_target);
        if (w_misalign)
            w_next_pc = TRAP_VECTOR;
        else if (w_redirect)
            w_next_pc = w_redir_target;
        else
            w_next_pc = pc_q + PC_STEP;
`else
        w_misalign     = 1'b0;
        w_next_pc      = w_redirect ? w_redir_target : (pc_q + PC_STEP);
`endif
    end

`ifndef PC_SEQ_ALIGN_CHECK_EN
    // The trap vector only matters when alignment checking is built in
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_VECTOR;
`endif

    // Next-state and update-cycle decode; reset suppresses any update
    always_comb begin
        state_d  = state_q;
        w_update = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (stall) begin
                        state_d = ST_HOLD;
                    end else begin
                        w_update = 1'b1;
                        state_d  = halt ? ST_HALTED : ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    w_update = 1'b1;
                    state_d  = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (run)
                    state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (rst)
            w_update = 1'b0;
    end

    // State register and retired-instruction counter (wraps naturally)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (w_update)
                retired_q <= retired_q + 32'd1;
        end
    end

    // Everything except the fetch address is forced low while in reset
    assign w_boot       = ~rst & (state_q == ST_BOOT);
    assign pc_ena       = w_boot | w_update;
    assign pc_d         = w_boot ? RESET_VECTOR : (w_update ? w_next_pc : 32'h0000_0000);
    assign imem_req     = ~rst & (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = imem_req & imem_ack;
    assign halted       = ~rst & (state_q == ST_HALTED);
    assign retired      = rst ? 32'h0000_0000 : retired_q;
    assign misalign_err = w_update & w_misalign;

endmodule
`default_nettype wire
